// File: rtl/core_pkg.sv
// Shared constants and status layout for the core debug register file.
package core;

  localparam int unsigned DBGI_STATUS = 1;
  localparam int unsigned DBGI_ITR3   = 3;
  localparam int unsigned DBGI_ITRCNT = 4;

  // Low 16 bits of the STATUS register; everything above reads as zero.
  typedef struct packed {
    logic [7:0] level;
    logic [5:0] rsvd;
    logic       valid;
    logic       overflow;
  } dbg_status_t;

endpackage

// File: rtl/core_dbg_regs_if.sv
// Debug request/response bus between the debug APB slave (master) and the core register file (slave).
interface core_dbg_regs_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                    dbg_req;
  logic                    dbg_wr_rd;
  logic [ADDR_WIDTH-1:0]   dbg_addr;
  logic [DATA_WIDTH-1:0]   dbg_wdata;
  logic [DATA_WIDTH/8-1:0] dbg_wstrobe;
  logic [DATA_WIDTH-1:0]   dbg_rdata;
  logic                    dbg_rd_ready;
  logic                    dbg_err;

  modport master (
    output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, dbg_wstrobe,
    input  dbg_rdata, dbg_rd_ready, dbg_err
  );

  modport slave (
    input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, dbg_wstrobe,
    output dbg_rdata, dbg_rd_ready, dbg_err
  );
endinterface

// File: rtl/dbg_itr_fifo.sv
// ITR instruction FIFO: any depth >= 2, pointers wrap at DEPTH-1, no push-to-head bypass.
module dbg_itr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is left unreset; an entry is only visible once the level covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/core_dbg_regs.sv
// Core-side debug register file with ITR injection FIFO toward Fetch.
// Optional pop counter register at DBGI_ITRCNT: define CORE_DBG_ITR_COUNT_EN.
module core_dbg_regs
  import core::*;
#(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int          ITR_DEPTH  = 4,
  parameter int unsigned ITR_REG    = core::DBGI_ITR3,
  parameter int unsigned STATUS_REG = core::DBGI_STATUS
) (
  input  logic                           clk,
  input  logic                           rst,
  core_dbg_regs_if.slave                 dbg,
  output logic                           itr_valid,
  output logic [31:0]                    itr_insn,
  input  logic                           itr_ready,
  output logic [$clog2(ITR_DEPTH+1)-1:0] itr_level,
  output logic                           itr_overflow
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q, cur_word, merged, rd_word;
  logic                  rd_ready_q, err_q, ovf_q, ovf_d;
  logic                  in_range, wr_en, rd_req, is_itr, is_status;
  logic                  itr_push, itr_pop, fifo_full, fifo_empty, ovf_set, status_clr;
  dbg_status_t           status;

  assign in_range  = 32'(dbg.dbg_addr) < NUM_REGS;
  assign wr_en     = dbg.dbg_req & dbg.dbg_wr_rd & in_range;
  assign rd_req    = dbg.dbg_req & ~dbg.dbg_wr_rd;
  assign is_itr    = (dbg.dbg_addr == ADDR_WIDTH'(ITR_REG));
  assign is_status = (dbg.dbg_addr == ADDR_WIDTH'(STATUS_REG));

`ifdef CORE_DBG_ITR_COUNT_EN
  logic [DATA_WIDTH-1:0] cnt_q;
  logic                  is_cnt;
  assign is_cnt = (dbg.dbg_addr == ADDR_WIDTH'(DBGI_ITRCNT));
`endif

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (dbg.dbg_addr == ADDR_WIDTH'(i)) cur_word = regs_q[i];
    end
  end

  always_comb begin
    for (int b = 0; b < BYTES; b++) begin
      merged[8*b +: 8] = dbg.dbg_wstrobe[b] ? dbg.dbg_wdata[8*b +: 8] : cur_word[8*b +: 8];
    end
  end

  always_comb begin
    status          = '0;
    status.overflow = ovf_q;
    status.valid    = ~fifo_empty;
    status.level    = 8'(itr_level);
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      if (is_status) rd_word = DATA_WIDTH'(status);
`ifdef CORE_DBG_ITR_COUNT_EN
      else if (is_cnt) rd_word = cnt_q;
`endif
      else rd_word = cur_word;
    end
  end

  assign itr_push   = wr_en & is_itr;
  assign itr_pop    = itr_valid & itr_ready;
  assign ovf_set    = itr_push & fifo_full & ~itr_pop;
  assign status_clr = wr_en & is_status & dbg.dbg_wstrobe[0] & dbg.dbg_wdata[0];
  // Set has priority over a clear landing in the same cycle.
  assign ovf_d      = ovf_set | (ovf_q & ~status_clr);

  dbg_itr_fifo #(
    .DEPTH (ITR_DEPTH),
    .WIDTH (32)
  ) u_itr_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (itr_push),
    .push_data_i (32'(merged)),
    .pop_i       (itr_pop),
    .head_o      (itr_insn),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (itr_level)
  );

  assign itr_valid    = ~fifo_empty;
  assign itr_overflow = ovf_q;

  // NOTE: the register array is reset because every register must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_en && dbg.dbg_addr == ADDR_WIDTH'(i) && i != int'(STATUS_REG)
`ifdef CORE_DBG_ITR_COUNT_EN
            && i != int'(DBGI_ITRCNT)
`endif
           ) begin
          regs_q[i] <= merged;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      rd_ready_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ready_q <= rd_req;
      err_q      <= dbg.dbg_req & ~in_range;
      ovf_q      <= ovf_d;
      if (rd_req) rdata_q <= rd_word;
    end
  end

`ifdef CORE_DBG_ITR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wr_en && is_cnt) begin
      cnt_q <= itr_pop ? DATA_WIDTH'(1) : '0;
    end else if (itr_pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  assign dbg.dbg_rdata    = rdata_q;
  assign dbg.dbg_rd_ready = rd_ready_q;
  assign dbg.dbg_err      = err_q;

endmodule
